cfg_chain_loader: RTL and testbench

- Serial configuration source for the logic-block configuration shift chain.
- Accepts configuration words over a valid/ready stream and shifts them MSB-first onto the chain as a bit plus shift-enable.
- Counts exactly CHAIN_LEN bits, then reports completion.
- Sits between the bitstream source (host/ROM) and the cascaded per-block configuration shift registers.

---
 rtl/cfg_chain_loader.sv | 99 +++++++++
 tb/tb_cfg_chain_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: streams configuration words MSB-first onto the logic-block
// configuration shift chain, counting exactly CHAIN_LEN bits per load sequence.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | in_ready high, waiting for the next configuration word
// SHIFT | one chain bit per cycle from the captured word
// DONE  | chain fully loaded, done held until the next start
module cfg_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 20,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_bit,
  output logic              cfg_shift,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_left
);

  localparam int WC_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] word_sr;
  logic [WC_W-1:0]   word_cnt;

  // Sequencer: every output is a register updated alongside the state.
  // cfg_bit is loaded with the word MSB at the accepting edge so the first
  // shift appears the very next cycle, and it is left untouched on the last
  // bit of a word so it holds while cfg_shift is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      cfg_bit   <= 1'b0;
      cfg_shift <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bits_left <= '0;
      word_sr   <= '0;
      word_cnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            bits_left <= LEN;
            busy      <= 1'b1;
            done      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            state     <= SHIFT;
            in_ready  <= 1'b0;
            cfg_shift <= 1'b1;
            cfg_bit   <= in_data[WORD_W-1];
            word_sr   <= in_data << 1;
            // a short final word only contributes its top bits_left bits
            if (int'(bits_left) < WORD_W)
              word_cnt <= WC_W'(bits_left);
            else
              word_cnt <= WC_W'(WORD_W);
          end
        end
        SHIFT: begin
          bits_left <= (bits_left != '0) ? bits_left - 1'b1 : '0;
          word_cnt  <= word_cnt - 1'b1;
          if (word_cnt <= WC_W'(1)) begin
            cfg_shift <= 1'b0;
            if (bits_left <= CNT_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end else begin
            cfg_bit <= word_sr[WORD_W-1];
            word_sr <= word_sr << 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: directed scenarios plus randomized words and
// stalls, checked against a queue model of the expected chain bit stream.
module tb_cfg_chain_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cfg_bit;
  logic              cfg_shift;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bits_left;

  int checks   = 0;
  int failures = 0;

  logic [WORD_W-1:0] word_q[$];
  bit                exp_q[$];
  bit                obs_q[$];

  cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .cfg_bit(cfg_bit),
    .cfg_shift(cfg_shift), .busy(busy), .done(done), .bits_left(bits_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected chain contents: top bits of each word, MSB first, until the chain is full.
  task automatic build_exp();
    int rem;
    int n;
    exp_q.delete();
    rem = CHAIN_LEN;
    foreach (word_q[i]) begin
      n = (rem < WORD_W) ? rem : WORD_W;
      for (int b = 0; b < n; b++) exp_q.push_back(word_q[i][WORD_W-1-b]);
      rem -= n;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_bit"},   32'(cfg_bit),  32'd0);
    check({tag, "_shift"}, 32'(cfg_shift), 32'd0);
    check({tag, "_busy"},  32'(busy),     32'd0);
    check({tag, "_done"},  32'(done),     32'd0);
    check({tag, "_bits"},  32'(bits_left), 32'd0);
  endtask

  // One load sequence. stall_word/stall_len: hold in_valid low that many LOAD
  // cycles before that word; rnd: random extra stalls; start_at: pulse start
  // during that shift; abort_at: assert reset after that many shifts.
  task automatic run_seq(input int stall_word, input int stall_len, input bit rnd,
                         input int start_at, input int abort_at);
    int idx = 0, nsh = 0, cyc = 0, stalled = 0;
    bit aborted = 0, last_sh = 0;
    logic [31:0] po = 0, pe = 0;
    obs_q.delete();
    build_exp();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_busy",  32'(busy), 32'd1);
    check("start_done",  32'(done), 32'd0);
    check("start_bits",  32'(bits_left), 32'(CHAIN_LEN));
    check("start_ready", 32'(in_ready), 32'd1);
    while (!done && cyc < 500) begin
      check("bits_left", 32'(bits_left), 32'(CHAIN_LEN - nsh));
      check("ready_vs_shift", 32'(in_ready && cfg_shift), 32'd0);
      last_sh = cfg_shift;
      if (cfg_shift) begin
        obs_q.push_back(cfg_bit);
        nsh++;
      end
      start = (start_at != 0) && cfg_shift && (nsh == start_at);
      if (abort_at != 0 && cfg_shift && nsh == abort_at) begin
        in_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("abort_idle_busy",  32'(busy), 32'd0);
        check("abort_idle_ready", 32'(in_ready), 32'd0);
        aborted = 1;
        break;
      end
      if (in_ready && idx < word_q.size()) begin
        if (idx == stall_word && stalled < stall_len) begin
          in_valid = 1'b0;
          check("stall_shift", 32'(cfg_shift), 32'd0);
          stalled++;
        end else if (rnd && $urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = word_q[idx];
          idx++;
        end
      end else begin
        // junk offered while not ready must never be consumed
        in_valid = 1'($urandom_range(0, 1));
        in_data  = WORD_W'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (!aborted) begin
      check("timeout",     32'(done), 32'd1);
      check("done_after_last_shift", 32'(last_sh), 32'd1);
      check("done_bits",   32'(bits_left), 32'd0);
      check("done_busy",   32'(busy), 32'd0);
      check("done_shift",  32'(cfg_shift), 32'd0);
      check("nshift",      32'(nsh), 32'(CHAIN_LEN));
      check("words_used",  32'(idx), 32'(NWORDS));
      if (stall_len > 0) check("stall_len", 32'(stalled), 32'(stall_len));
      foreach (obs_q[i]) po = {po[30:0], obs_q[i]};
      foreach (exp_q[i]) pe = {pe[30:0], exp_q[i]};
      check("stream", po, pe);
      repeat (3) begin
        @(negedge clk);
        check("done_hold",     32'(done), 32'd1);
        check("no_extra_shift", 32'(cfg_shift), 32'd0);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #3;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd0);
    check("idle_busy",  32'(busy), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (2) @(negedge clk);
    check("idle_valid_ignored", 32'({busy, in_ready, cfg_shift}), 32'd0);
    in_valid = 1'b0;

    word_q = '{8'hA5, 8'h3C, 8'hF0};
    build_exp();
    check("model_len", 32'(exp_q.size()), 32'(CHAIN_LEN));
    run_seq(-1, 0, 0, 0, 0);
    run_seq(1, 5, 0, 0, 0);
    run_seq(-1, 0, 0, 3, 0);
    run_seq(-1, 0, 0, 0, 10);
    run_seq(-1, 0, 0, 0, 0);
    word_q = '{8'hFF, 8'h00, 8'h80};
    run_seq(-1, 0, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      word_q.delete();
      for (int w = 0; w < NWORDS + 1; w++) word_q.push_back(WORD_W'($urandom));
      run_seq(-1, 0, 1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
